// File: rtl/cmul_seq_ctrl.sv
// Complex multiply sequencer: one shared 32x32 multiplier, four partial products per request.
// Optional macro CMUL_CONJ_EN adds the conj port and a*conj(b) mode.
module cmul_seq_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef CMUL_CONJ_EN
    input  logic        conj,
`endif
    input  logic [31:0] ar,
    input  logic [31:0] ai,
    input  logic [31:0] br,
    input  logic [31:0] bi,
    output logic        busy,
    output logic        done,
    output logic [63:0] pr,
    output logic [63:0] pi,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p
);

    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL0 = 3'd1,
        ST_MUL1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_MUL3 = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          last_s;
    logic          conj_in_s;

    logic [31:0] ar_r, ai_r, br_r, bi_r;
    logic [31:0] ar_nx_s, ai_nx_s, br_nx_s, bi_nx_s;
    logic        conj_r, conj_nx_s;
    logic [63:0] acc_re_r, acc_im_r;
    logic [63:0] acc_re_nx_s, acc_im_nx_s;
    logic [63:0] pr_nx_s, pi_nx_s;
    logic [31:0] mul_a_nx_s, mul_b_nx_s;
    logic        busy_nx_s, done_nx_s;

`ifdef CMUL_CONJ_EN
    assign conj_in_s = conj;
`else
    assign conj_in_s = 1'b0;
`endif

    assign last_s = (cnt_r == CNT_LAST);

    // State and dwell counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state: each MULn state dwells MUL_LAT cycles
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = {CW{1'b0}};
                if (start) begin
                    state_nx_s = ST_MUL0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL0, ST_MUL1, ST_MUL2, ST_MUL3: begin
                if (last_s) begin
                    cnt_nx_s = {CW{1'b0}};
                    case (state_r)
                        ST_MUL0: state_nx_s = ST_MUL1;
                        ST_MUL1: state_nx_s = ST_MUL2;
                        ST_MUL2: state_nx_s = ST_MUL3;
                        default: state_nx_s = ST_IDLE;
                    endcase
                end else begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output/datapath next values; operands only move on state-entry edges
    always_comb begin
        ar_nx_s     = ar_r;
        ai_nx_s     = ai_r;
        br_nx_s     = br_r;
        bi_nx_s     = bi_r;
        conj_nx_s   = conj_r;
        acc_re_nx_s = acc_re_r;
        acc_im_nx_s = acc_im_r;
        pr_nx_s     = pr;
        pi_nx_s     = pi;
        mul_a_nx_s  = mul_a;
        mul_b_nx_s  = mul_b;
        done_nx_s   = 1'b0;
        busy_nx_s   = (state_nx_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    ar_nx_s    = ar;
                    ai_nx_s    = ai;
                    br_nx_s    = br;
                    bi_nx_s    = bi;
                    conj_nx_s  = conj_in_s;
                    mul_a_nx_s = ar;
                    mul_b_nx_s = br;
                end else begin
                    mul_a_nx_s = mul_a;
                end
            end
            ST_MUL0: begin
                if (last_s) begin
                    acc_re_nx_s = mul_p;
                    mul_a_nx_s  = ai_r;
                    mul_b_nx_s  = bi_r;
                end else begin
                    acc_re_nx_s = acc_re_r;
                end
            end
            ST_MUL1: begin
                if (last_s) begin
                    if (conj_r) begin
                        acc_re_nx_s = acc_re_r + mul_p;
                    end else begin
                        acc_re_nx_s = acc_re_r - mul_p;
                    end
                    mul_a_nx_s = ar_r;
                    mul_b_nx_s = bi_r;
                end else begin
                    acc_re_nx_s = acc_re_r;
                end
            end
            ST_MUL2: begin
                if (last_s) begin
                    acc_im_nx_s = mul_p;
                    mul_a_nx_s  = ai_r;
                    mul_b_nx_s  = br_r;
                end else begin
                    acc_im_nx_s = acc_im_r;
                end
            end
            ST_MUL3: begin
                if (last_s) begin
                    pr_nx_s = acc_re_r;
                    if (conj_r) begin
                        pi_nx_s = mul_p - acc_im_r;
                    end else begin
                        pi_nx_s = acc_im_r + mul_p;
                    end
                    done_nx_s = 1'b1;
                end else begin
                    done_nx_s = 1'b0;
                end
            end
            default: begin
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_r     <= 32'd0;
            ai_r     <= 32'd0;
            br_r     <= 32'd0;
            bi_r     <= 32'd0;
            conj_r   <= 1'b0;
            acc_re_r <= 64'd0;
            acc_im_r <= 64'd0;
            pr       <= 64'd0;
            pi       <= 64'd0;
            mul_a    <= 32'd0;
            mul_b    <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ar_r     <= ar_nx_s;
            ai_r     <= ai_nx_s;
            br_r     <= br_nx_s;
            bi_r     <= bi_nx_s;
            conj_r   <= conj_nx_s;
            acc_re_r <= acc_re_nx_s;
            acc_im_r <= acc_im_nx_s;
            pr       <= pr_nx_s;
            pi       <= pi_nx_s;
            mul_a    <= mul_a_nx_s;
            mul_b    <= mul_b_nx_s;
            busy     <= busy_nx_s;
            done     <= done_nx_s;
        end
    end

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// Scoreboard bench for cmul_seq_ctrl at MUL_LAT=1 (combinational multiplier) and MUL_LAT=3 (pipelined).
module tb_cmul_seq_ctrl;

    typedef struct packed {
        logic [63:0] pr;
        logic [63:0] pi;
        logic [31:0] ma;
        logic [31:0] mb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start1, start3;
    logic        conj;
    logic [31:0] ar, ai, br, bi;
    logic        busy1, done1, busy3, done3;
    logic [63:0] pr1, pi1, pr3, pi3;
    logic [31:0] mul_a1, mul_b1, mul_a3, mul_b3;
    logic [63:0] mul_p1, mul_p3;
    logic [63:0] p3_d1, p3_d2;

    exp_t q1[$];
    exp_t q3[$];
    int   checks = 0;
    int   errors = 0;

    cmul_seq_ctrl #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef CMUL_CONJ_EN
        .conj(conj),
`endif
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .busy(busy1), .done(done1), .pr(pr1), .pi(pi1),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1)
    );

    cmul_seq_ctrl #(.MUL_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef CMUL_CONJ_EN
        .conj(conj),
`endif
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .busy(busy3), .done(done3), .pr(pr3), .pi(pi3),
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multipliers: combinational for LAT=1, two register stages for LAT=3
    assign mul_p1 = {32'd0, mul_a1} * {32'd0, mul_b1};
    always @(posedge clk) begin
        p3_d1 <= {32'd0, mul_a3} * {32'd0, mul_b3};
        p3_d2 <= p3_d1;
    end
    assign mul_p3 = p3_d2;

    function automatic logic [63:0] e_pr(input logic [31:0] a_r, a_i, b_r, b_i, input logic c);
        logic [63:0] p1, p2;
        p1 = {32'd0, a_r} * {32'd0, b_r};
        p2 = {32'd0, a_i} * {32'd0, b_i};
        return c ? (p1 + p2) : (p1 - p2);
    endfunction

    function automatic logic [63:0] e_pi(input logic [31:0] a_r, a_i, b_r, b_i, input logic c);
        logic [63:0] p1, p2;
        p1 = {32'd0, a_r} * {32'd0, b_i};
        p2 = {32'd0, a_i} * {32'd0, b_r};
        return c ? (p2 - p1) : (p1 + p2);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: request is accepted on the next posedge; returns one negedge later
    task automatic issue(input int d, input logic [31:0] a_r, a_i, b_r, b_i, input logic c);
        exp_t e;
        ar = a_r; ai = a_i; br = b_r; bi = b_i; conj = c;
        e.pr = e_pr(a_r, a_i, b_r, b_i, c);
        e.pi = e_pi(a_r, a_i, b_r, b_i, c);
        e.ma = a_i;
        e.mb = b_r;
        if (d == 1) begin
            start1 = 1'b1;
            q1.push_back(e);
        end else begin
            start3 = 1'b1;
            q3.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int exp_lat, input string tag);
        int   n = 0;
        int   nb = 0;
        int   qs;
        logic dn, bz;
        exp_t e;
        dn = (d == 1) ? done1 : done3;
        bz = (d == 1) ? busy1 : busy3;
        while (!dn && n < 200) begin
            if (bz) nb++;
            @(negedge clk);
            n++;
            dn = (d == 1) ? done1 : done3;
            bz = (d == 1) ? busy1 : busy3;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
        check({tag, "_busy_at_done"}, {63'd0, bz}, 64'd0);
        qs = (d == 1) ? q1.size() : q3.size();
        check({tag, "_sb_depth"}, 64'(qs), 64'd1);
        if (qs > 0) begin
            e = (d == 1) ? q1.pop_front() : q3.pop_front();
            check({tag, "_pr"}, (d == 1) ? pr1 : pr3, e.pr);
            check({tag, "_pi"}, (d == 1) ? pi1 : pi3, e.pi);
            check({tag, "_mul_a_hold"}, {32'd0, (d == 1) ? mul_a1 : mul_a3}, {32'd0, e.ma});
            check({tag, "_mul_b_hold"}, {32'd0, (d == 1) ? mul_b1 : mul_b3}, {32'd0, e.mb});
        end
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; conj = 1'b0;
        ar = 32'd0; ai = 32'd0; br = 32'd0; bi = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy1", {63'd0, busy1}, 64'd0);
        check("rst_done1", {63'd0, done1}, 64'd0);
        check("rst_pr1", pr1, 64'd0);
        check("rst_pi1", pi1, 64'd0);
        check("rst_mul_a1", {32'd0, mul_a1}, 64'd0);
        check("rst_mul_b1", {32'd0, mul_b1}, 64'd0);
        check("rst_busy3", {63'd0, busy3}, 64'd0);
        check("rst_pr3", pr3, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 32'd31, 32'd22, 32'd103, 32'd43, 1'b0);
        wait_done(1, 4, "basic");
        check("basic_pr_const", pr1, 64'd2247);
        check("basic_pi_const", pi1, 64'd3599);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done1}, 64'd0);

        issue(1, 32'd83, 32'd99, 32'd45, 32'd68, 1'b0);
        wait_done(1, 4, "neg");
        check("neg_pr_const", pr1, 64'hFFFF_FFFF_FFFF_F44B);
        check("neg_pi_const", pi1, 64'd10099);
        @(negedge clk);

        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(1, 4, "wrap");
        check("wrap_pi_const", pi1, 64'hFFFF_FFFC_0000_0002);
        @(negedge clk);

        // Start during busy is ignored, start in the done cycle is accepted
        issue(1, 32'd5, 32'd7, 32'd11, 32'd13, 1'b0);
        ar = 32'd1000; ai = 32'd2000; br = 32'd3000; bi = 32'd4000; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 3, "ignore");
        issue(1, 32'd100, 32'd200, 32'd300, 32'd400, 1'b0);
        wait_done(1, 4, "b2b");
        @(negedge clk);

        issue(3, 32'd31, 32'd22, 32'd103, 32'd43, 1'b0);
        ar = 32'd777; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(3, 11, "lat3_ignore");
        issue(3, 32'd83, 32'd99, 32'd45, 32'd68, 1'b0);
        wait_done(3, 12, "lat3_b2b");
        @(negedge clk);

        // Asynchronous reset while in MUL2 aborts without a done
        issue(1, 32'd9, 32'd8, 32'd7, 32'd6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy1}, 64'd0);
        check("abort_done", {63'd0, done1}, 64'd0);
        check("abort_pr", pr1, 64'd0);
        check("abort_pi", pi1, 64'd0);
        check("abort_mul_a", {32'd0, mul_a1}, 64'd0);
        check("abort_mul_b", {32'd0, mul_b1}, 64'd0);
        void'(q1.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        issue(1, 32'd12, 32'd34, 32'd56, 32'd78, 1'b0);
        wait_done(1, 4, "post_reset");
        @(negedge clk);

`ifdef CMUL_CONJ_EN
        issue(1, 32'd31, 32'd22, 32'd103, 32'd43, 1'b1);
        wait_done(1, 4, "conj1");
        check("conj1_pr_const", pr1, 64'd4139);
        check("conj1_pi_const", pi1, 64'd933);
        @(negedge clk);
        issue(1, 32'd31, 32'd22, 32'd103, 32'd43, 1'b0);
        wait_done(1, 4, "conj0");
        check("conj0_pr_const", pr1, 64'd2247);
        check("conj0_pi_const", pi1, 64'd3599);
        @(negedge clk);
        issue(3, 32'd83, 32'd99, 32'd45, 32'd68, 1'b1);
        wait_done(3, 12, "conj_lat3");
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
